// File: rtl/alu_control_unit_pkg.sv
// Shared constants for the arithmetic_unit sequencer: opcodes, FSM states,
// control-line indices and the fixed iteration count.
package alu_control_unit_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int ITER  = 8;
  localparam int NCTRL = 11;

  localparam int C_LDQ     = 0;
  localparam int C_LDM     = 1;
  localparam int C_LDA     = 2;
  localparam int C_SUB     = 3;
  localparam int C_SHIFT   = 4;
  localparam int C_INC     = 5;
  localparam int C_SHIN    = 6;
  localparam int C_CLR     = 7;
  localparam int C_SET     = 8;
  localparam int C_RESTORE = 9;
  localparam int C_VALID   = 10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOAD_Q    = 4'd1,
    LOAD_M    = 4'd2,
    ADDSUB    = 4'd3,
    MUL_TEST  = 4'd4,
    MUL_SHIFT = 4'd5,
    DIV_SHIFT = 4'd6,
    DIV_SUB   = 4'd7,
    DIV_FIX   = 4'd8,
    DONE      = 4'd9
  } state_t;

endpackage

// File: rtl/alu_control_unit.sv
// Sequencer that turns a start pulse and opcode into the c0..c10 strobes for
// add, sub, shift-add multiply and restoring divide on arithmetic_unit.
module alu_control_unit
  import alu_control_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             q_lsb,
  input  logic             a_msb,
  input  logic             m_zero,
  input  logic             carry,
  output logic [NCTRL-1:0] ctrl,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Handshake: start is accepted only on a rising edge while busy is low;
  // busy then stays high through the one-cycle done pulse, and start seen
  // while busy is dropped rather than queued.

  state_t      state;
  state_t      state_next;
  logic [1:0]  op_q;
  logic [3:0]  cnt;
  logic        last_q;
  logic        carry_q;
  logic        err_q;
  logic        first_div;
  logic        final_inc;

  assign first_div = (cnt == 4'd0);
  assign final_inc = (cnt == 4'(ITER - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= OP_ADD;
      cnt     <= 4'd0;
      last_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        op_q  <= op;
        err_q <= 1'b0;
      end
      if (state == LOAD_M) begin
        cnt     <= 4'd0;
        last_q  <= 1'b0;
        carry_q <= 1'b0;
      end else if (ctrl[C_INC]) begin
        cnt <= cnt + 4'd1;
        if (final_inc) last_q <= 1'b1;
      end
      // Adder carry is captured with the A load so the right shift can feed it back in.
      if (state == MUL_TEST) carry_q <= q_lsb & carry;
      if (state == DIV_SHIFT && first_div && m_zero) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    ctrl       = '0;
    unique case (state)
      IDLE: begin
        if (start) state_next = LOAD_Q;
      end
      LOAD_Q: begin
        ctrl[C_LDQ] = 1'b1;
        state_next  = LOAD_M;
      end
      LOAD_M: begin
        ctrl[C_LDM] = 1'b1;
        ctrl[C_CLR] = op_q[1];
        case (op_q)
          OP_ADD, OP_SUB: state_next = ADDSUB;
          OP_MUL:         state_next = MUL_TEST;
          default:        state_next = DIV_SHIFT;
        endcase
      end
      ADDSUB: begin
        ctrl[C_SUB] = op_q[0];
        state_next  = DONE;
      end
      MUL_TEST: begin
        ctrl[C_LDA] = q_lsb;
        state_next  = MUL_SHIFT;
      end
      MUL_SHIFT: begin
        ctrl[C_SHIFT] = 1'b1;
        ctrl[C_INC]   = 1'b1;
        ctrl[C_SHIN]  = carry_q;
        state_next    = final_inc ? DONE : MUL_TEST;
      end
      DIV_SHIFT: begin
        // A zero divisor is only checked before the first iteration starts.
        if (first_div && m_zero) begin
          state_next = DONE;
        end else begin
          ctrl[C_SHIFT] = 1'b1;
          state_next    = DIV_SUB;
        end
      end
      DIV_SUB: begin
        ctrl[C_LDA] = 1'b1;
        ctrl[C_SUB] = 1'b1;
        ctrl[C_INC] = 1'b1;
        state_next  = DIV_FIX;
      end
      DIV_FIX: begin
        if (a_msb) begin
          ctrl[C_LDA]     = 1'b1;
          ctrl[C_RESTORE] = 1'b1;
        end else begin
          ctrl[C_SET] = 1'b1;
        end
        state_next = last_q ? DONE : DIV_SHIFT;
      end
      DONE: begin
        ctrl[C_VALID] = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = ctrl[C_VALID];
  assign err  = err_q;

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit with a small arithmetic_unit model
// closing the status loop so multiply and divide produce real results.
module tb_alu_control_unit;
  import alu_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        q_lsb;
  logic        a_msb;
  logic        m_zero;
  logic        carry;
  logic [10:0] ctrl;
  logic        busy;
  logic        done;
  logic        err;

  // datapath model state
  logic [7:0]  a_r = 8'h00;
  logic [7:0]  q_r = 8'h00;
  logic [7:0]  m_r = 8'h00;
  logic [15:0] as_res = 16'h0000;
  logic        prev_c1 = 1'b0;
  logic [7:0]  opnd_x = 8'h00;
  logic [7:0]  opnd_y = 8'h00;
  logic [1:0]  cur_op = 2'b00;
  logic [8:0]  sum9;
  logic [7:0]  in_bus;

  // per-run observations
  logic [10:0] trace [1:40];
  int          n_lda;
  int          n_shift;
  int          n_inc;
  int          n_bad_restore;
  logic [7:0]  qbits;
  logic        err_c1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_control_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .q_lsb  (q_lsb),
    .a_msb  (a_msb),
    .m_zero (m_zero),
    .carry  (carry),
    .ctrl   (ctrl),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  assign in_bus = ctrl[C_LDQ] ? opnd_x : opnd_y;
  assign sum9   = ctrl[C_SUB] ? ({1'b0, a_r} - {1'b0, m_r}) : ({1'b0, a_r} + {1'b0, m_r});
  assign q_lsb  = q_r[0];
  assign a_msb  = a_r[7];
  assign m_zero = (m_r == 8'h00);
  assign carry  = sum9[8];

  always @(posedge clk) begin
    prev_c1 <= ctrl[C_LDM];
    if (prev_c1 && !cur_op[1])
      as_res <= ctrl[C_SUB] ? ({8'h00, q_r} - {8'h00, m_r}) : ({8'h00, q_r} + {8'h00, m_r});
    if (ctrl[C_LDQ]) q_r <= in_bus;
    if (ctrl[C_LDM]) m_r <= in_bus;
    if (ctrl[C_CLR]) a_r <= 8'h00;
    if (ctrl[C_LDA]) a_r <= sum9[7:0];
    if (ctrl[C_SHIFT]) begin
      if (cur_op == OP_MUL) {a_r, q_r} <= {ctrl[C_SHIN], a_r, q_r[7:1]};
      else                  {a_r, q_r} <= {a_r[6:0], q_r, ctrl[C_SHIN]};
    end
    if (ctrl[C_SET]) q_r[0] <= 1'b1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input int exp_cyc, input logic [15:0] exp_z,
                        input logic exp_err, input logic poke);
    int          done_cyc;
    logic [15:0] z_obs;
    logic        err_obs;
    done_cyc = 0;
    z_obs = 16'h0000;
    err_obs = 1'b0;
    n_lda = 0;
    n_shift = 0;
    n_inc = 0;
    n_bad_restore = 0;
    qbits = 8'h00;
    err_c1 = 1'b0;
    @(negedge clk);
    opnd_x = x;
    opnd_y = y;
    cur_op = o;
    op = o;
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        op = ~o;
        err_c1 = err;
      end
      if (poke && cyc == 5) begin
        start = 1'b1;
        op = OP_ADD;
      end
      if (poke && cyc == 6) start = 1'b0;
      trace[cyc] = ctrl;
      if (ctrl[C_LDA]) n_lda++;
      if (ctrl[C_SHIFT]) n_shift++;
      if (ctrl[C_INC]) n_inc++;
      if (ctrl[C_RESTORE] && (ctrl[C_SUB] || !ctrl[C_LDA])) n_bad_restore++;
      if (ctrl[C_SET]) qbits = {qbits[6:0], 1'b1};
      if (ctrl[C_RESTORE]) qbits = {qbits[6:0], 1'b0};
      if (done) begin
        done_cyc = cyc;
        z_obs = cur_op[1] ? {a_r, q_r} : as_res;
        err_obs = err;
        break;
      end
    end
    check_val({tag, " done_cycle"}, done_cyc, exp_cyc);
    check_val({tag, " z"}, z_obs, exp_z);
    check_val({tag, " err"}, err_obs, exp_err);
  endtask

  initial begin
    #1;
    check_val("reset ctrl", ctrl, 0);
    check_val("reset busy", busy, 0);
    check_val("reset done", done, 0);
    check_val("reset err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("add", OP_ADD, 8'h25, 8'h17, 4, 16'h003C, 1'b0, 1'b0);
    check_val("add ctrl c1", trace[1], 11'h001);
    check_val("add ctrl c2", trace[2], 11'h002);
    check_val("add ctrl c3", trace[3], 11'h000);
    check_val("add ctrl c4", trace[4], 11'h400);

    run_op("sub", OP_SUB, 8'h10, 8'h20, 4, 16'hFFF0, 1'b0, 1'b0);
    check_val("sub ctrl c3", trace[3], 11'h008);

    run_op("mul_ff", OP_MUL, 8'hFF, 8'hFF, 19, 16'hFE01, 1'b0, 1'b1);
    check_val("mul_ff shifts", n_shift, 8);
    check_val("mul_ff incs", n_inc, 8);
    check_val("mul_ff loads", n_lda, 8);
    check_val("mul_ff ctrl c2", trace[2], 11'h082);
    @(negedge clk);
    check_val("mul_ff done pulse", done, 0);
    check_val("mul_ff idle busy", busy, 0);

    run_op("mul_13x11", OP_MUL, 8'h0D, 8'h0B, 19, 16'h008F, 1'b0, 1'b0);
    check_val("mul_13x11 loads", n_lda, 3);

    run_op("div_200_7", OP_DIV, 8'd200, 8'd7, 27, 16'h041C, 1'b0, 1'b0);
    check_val("div_200_7 qbits", qbits, 8'h1C);
    check_val("div_200_7 shifts", n_shift, 8);
    check_val("div_200_7 incs", n_inc, 8);
    check_val("div_200_7 loads", n_lda, 13);
    check_val("div_200_7 restore form", n_bad_restore, 0);

    run_op("div_zero", OP_DIV, 8'h55, 8'h00, 4, 16'h0055, 1'b1, 1'b0);
    check_val("div_zero loads", n_lda, 0);
    check_val("div_zero shifts", n_shift, 0);
    @(negedge clk);
    check_val("div_zero err held", err, 1);

    run_op("add_after_err", OP_ADD, 8'h80, 8'h80, 4, 16'h0100, 1'b0, 1'b0);
    check_val("add_after_err cleared", err_c1, 0);

    run_op("div_255_16", OP_DIV, 8'hFF, 8'h10, 27, 16'h0F0F, 1'b0, 1'b0);
    check_val("div_255_16 qbits", qbits, 8'h0F);

    // reset in the middle of a multiply
    @(negedge clk);
    opnd_x = 8'h0F;
    opnd_y = 8'h03;
    cur_op = OP_MUL;
    op = OP_MUL;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_val("midrst busy before", busy, 1);
    rst = 1'b0;
    #1;
    check_val("midrst ctrl", ctrl, 0);
    check_val("midrst busy", busy, 0);
    check_val("midrst done", done, 0);
    check_val("midrst err", err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("post_rst idle", {busy, done}, 0);
    end

    run_op("add_post_rst", OP_ADD, 8'h7F, 8'h01, 4, 16'h0080, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
